xnor_conv_accum: RTL and testbench
==================================

XNOR_CONV_ACCUM -- requirements
Module: xnor_conv_accum

Interface
REQ-001 The module SHALL have parameter IN_WIDTH, default 25: bits per lane per chunk (minimum 1).
REQ-002 The module SHALL have parameter LANES, default 4: independent output channels processed in parallel.
REQ-003 The module SHALL have parameter ACC_WIDTH, default 16: signed accumulator/result width per lane; the minimum is ceil(log2(IN_WIDTH+1))+2.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port in_valid, input, 1 bit: a chunk is presented.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the block can accept a chunk.
REQ-008 The module SHALL have port in_a, input, LANES*IN_WIDTH bits: binary activations; lane k occupies bits [k*IN_WIDTH +: IN_WIDTH].
REQ-009 The module SHALL have port in_b, input, LANES*IN_WIDTH bits: binary weights, using the same lane packing as in_a.
REQ-010 The module SHALL have port in_last, input, 1 bit: the presented chunk is the final chunk of the current dot product.
REQ-011 The module SHALL have port out_valid, output, 1 bit: a result is held.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The module SHALL have port out_c, output, LANES*ACC_WIDTH bits, signed per lane: the dot-product results.
REQ-014 The module SHALL have port out_sat, output, LANES bits: per lane, set if saturation occurred anywhere during the result.

Function
REQ-015 Definitions:
- accept = in_valid && in_ready.
- Per-lane chunk term t_k = 2*popcount(~(a_k ^ b_k)) - IN_WIDTH, a signed value in [-IN_WIDTH, +IN_WIDTH].
REQ-016 The state machine SHALL have states IDLE, ACCUM and DONE; reset SHALL enter IDLE.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and SHALL be 0 in DONE.
REQ-018 On accept in IDLE, each lane accumulator SHALL load t_k (it does not add to its old value), and the sat flags SHALL clear.
REQ-019 On accept in ACCUM, each lane SHALL set acc_k = sat(acc_k + t_k).
REQ-020 sat() SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], and SHALL set the sticky out_sat bit of that lane whenever clamping occurs.
REQ-021 Transition rules:
- accept with in_last=0: the next state SHALL be ACCUM.
- accept with in_last=1: the next state SHALL be DONE.
- No accept: the state SHALL be unchanged.
REQ-022 In DONE, out_valid SHALL be 1 and out_c SHALL present the lane accumulators.
- out_valid SHALL rise in the cycle after the in_last chunk is accepted (latency 1).
REQ-023 In DONE, out_c and out_sat SHALL hold stable until out_valid && out_ready; at that edge the state SHALL go to IDLE.
REQ-024 A single-chunk job (in_last=1 accepted in IDLE) SHALL produce out_c = t_k, with no saturation possible given the ACC_WIDTH minimum.
REQ-025 While out_ready=1 in DONE, the next chunk SHALL NOT be accepted in the same cycle; the throughput penalty is one bubble per job.
REQ-026 in_a, in_b and in_last SHALL be ignored when no accept occurs; in_valid in DONE SHALL have no effect.
REQ-027 The only combinational paths SHALL be to the internal adders; in_ready, out_valid, out_c and out_sat SHALL be driven purely from registers.

Reset
REQ-028 While reset=1, independent of clock:
- state SHALL be IDLE;
- all accumulators, out_c and out_sat SHALL be 0;
- out_valid SHALL be 0 and in_ready SHALL be 0.
REQ-029 in_ready SHALL be 1 from the first clock edge after reset deasserts.
REQ-030 Reset asserted mid-job (ACCUM or DONE) SHALL discard the partial or held result; after release, the next accept SHALL start a fresh job.

Verification (IN_WIDTH=25, LANES=4, ACC_WIDTH=16)
REQ-031 Single chunk:
- stimulus: lane0 a=b=all ones, lane1 a=~b, lane2 a=b=0, lane3 a=0 with b=0x000FFF, in_last=1;
- required response: the next cycle out_valid=1, out_c={lane3:1, lane2:25, lane1:-25, lane0:25}, out_sat=0.
REQ-032 Three-chunk job:
- stimulus: lane0 receives a=b all ones on all three chunks, in_last set on the third;
- required response: in_ready=1 throughout, out_c lane0=75, and out_valid=1 exactly one cycle after the third accept.
REQ-033 Backpressure:
- stimulus: hold out_ready=0 for 5 cycles in DONE while in_valid=1;
- required response: in_ready=0, out_c is stable, and no chunk is accepted; out_ready=1 then gives IDLE on the next edge with in_ready=1.
REQ-034 Saturation:
- stimulus: ACC_WIDTH=8, lane0 all-match over 6 chunks (true sum 150);
- required response: out_c lane0=127, out_sat[0]=1, and the next job starts with out_sat[0]=0.
REQ-035 Reset mid-job:
- stimulus: accept 2 chunks, assert reset asynchronously between edges;
- required response: out_valid=0 and out_c=0 immediately; after release, a single chunk with lane0 all-match yields out_c lane0=25, not 75.

Source files
------------

// File: rtl/xnor_conv_accum_if.sv
// Chunk-in / result-out handshake bundle for the XNOR dot-product accumulator.
interface xnor_conv_accum_if #(
  parameter int unsigned IN_WIDTH  = 25,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_WIDTH = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*IN_WIDTH-1:0]  in_a;
  logic [LANES*IN_WIDTH-1:0]  in_b;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*ACC_WIDTH-1:0] out_c;
  logic [LANES-1:0]           out_sat;

  // Producer/consumer side.
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_c, out_sat
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_c, out_sat
  );
endinterface

// File: rtl/xnor_conv_accum.sv
// Binary (XNOR/popcount) dot-product accumulator. Each lane turns a chunk into a signed term
// 2*matches - IN_WIDTH, accumulates with saturation across a job, and holds the result until
// the consumer takes it. All outputs come straight from flops.
module xnor_conv_accum #(
  parameter int unsigned IN_WIDTH  = 25,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_WIDTH = 16
) (
  input logic                clock,
  input logic                reset,
  xnor_conv_accum_if.slave   bus
);

  localparam int unsigned PcWidth = $clog2(IN_WIDTH + 1);
  // One extra bit so the pre-clamp sum can never wrap.
  localparam int unsigned SumW    = ACC_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e state_q, state_d;
  logic   in_ready_q, out_valid_q;
  logic   accept;

  logic [ACC_WIDTH-1:0] acc_q [LANES];
  logic [ACC_WIDTH-1:0] acc_d [LANES];
  logic [LANES-1:0]     sat_q, sat_d;

  logic [SumW-1:0] term [LANES];
  logic [SumW-1:0] sum  [LANES];

  assign accept = bus.in_valid && in_ready_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IN_WIDTH-1:0] match;
    logic [PcWidth-1:0]  pc;

    assign match = ~(bus.in_a[k*IN_WIDTH +: IN_WIDTH] ^ bus.in_b[k*IN_WIDTH +: IN_WIDTH]);

    // Count matching bit positions in this lane's chunk.
    always_comb begin
      pc = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
        pc = pc + PcWidth'(match[i]);
      end
    end

    assign term[k] = (SumW'(pc) << 1) - SumW'(IN_WIDTH);
    assign sum[k]  = {acc_q[k][ACC_WIDTH-1], acc_q[k]} + term[k];

    assign bus.out_c[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[k];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sat   = sat_q;

  // Next state: chunks are taken in Idle/Accum, the held result leaves Done on out_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          state_d = bus.in_last ? StDone : StAccum;
        end
      end
      StDone: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Accumulator update: first chunk of a job loads, later chunks add with clamping.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      acc_d[k] = acc_q[k];
      sat_d[k] = sat_q[k];
      if (accept) begin
        if (state_q == StIdle) begin
          // |term| <= IN_WIDTH always fits, so a fresh job cannot saturate here.
          acc_d[k] = term[k][ACC_WIDTH-1:0];
          sat_d[k] = 1'b0;
        end else if (sum[k][SumW-1] != sum[k][SumW-2]) begin
          acc_d[k] = sum[k][SumW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          sat_d[k] = 1'b1;
        end else begin
          acc_d[k] = sum[k][ACC_WIDTH-1:0];
        end
      end
    end
  end

  // State, handshake flags and accumulators; handshake flags are registered from next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= '0;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != StDone);
      out_valid_q <= (state_d == StDone);
      sat_q       <= sat_d;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

endmodule

// File: tb/tb_xnor_conv_accum.sv
// Directed bench for xnor_conv_accum: single-chunk vector table plus multi-chunk,
// backpressure, saturation (ACC_WIDTH=8 instance) and mid-job reset sequences.
module tb_xnor_conv_accum;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  xnor_conv_accum_if #(.IN_WIDTH(25), .LANES(4), .ACC_WIDTH(16)) bus ();
  xnor_conv_accum_if #(.IN_WIDTH(25), .LANES(4), .ACC_WIDTH(8))  bus8 ();

  xnor_conv_accum #(.IN_WIDTH(25), .LANES(4), .ACC_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  xnor_conv_accum #(.IN_WIDTH(25), .LANES(4), .ACC_WIDTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  typedef struct {
    string        name;
    logic [99:0]  a;
    logic [99:0]  b;
    logic [63:0]  c;
  } vec_t;

  vec_t vecs [3];
  int   tests  = 0;
  int   failed = 0;

  localparam logic [99:0] AllOnes = {4{25'h1FFFFFF}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one chunk to the 16-bit instance; returns #1 after the accepting edge.
  task automatic send(input logic [99:0] a, input logic [99:0] b, input logic last);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [99:0] a, input logic [99:0] b, input logic last);
    @(negedge clock);
    bus8.in_valid = 1'b1;
    bus8.in_a     = a;
    bus8.in_b     = b;
    bus8.in_last  = last;
    @(posedge clock);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  // Pulse out_ready for one edge on the 16-bit instance.
  task automatic drain();
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic drain8();
    @(negedge clock);
    bus8.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus8.out_ready = 1'b0;
  endtask

  logic [99:0] a8, b8;

  initial begin
    // lanes packed {lane3, lane2, lane1, lane0}
    vecs[0].name = "single_chunk_ref";
    vecs[0].a = {25'h0000000, 25'h0000000, 25'h1FFFFFF, 25'h1FFFFFF};
    vecs[0].b = {25'h0000FFF, 25'h0000000, 25'h0000000, 25'h1FFFFFF};
    vecs[0].c = {16'd1, 16'd25, 16'hFFE7, 16'd25};
    vecs[1].name = "single_chunk_alt";
    vecs[1].a = {25'h00000FF, 25'h1555555, 25'h1555555, 25'h0000001};
    vecs[1].b = {25'h0000000, 25'h0AAAAAA, 25'h1555555, 25'h0000000};
    vecs[1].c = {16'd9, 16'hFFE7, 16'd25, 16'd23};
    vecs[2].name = "single_chunk_mix";
    vecs[2].a = {25'h1000000, 25'h0000000, 25'h0F0F0F0, 25'h1FFFFFF};
    vecs[2].b = {25'h0000000, 25'h1FFFFFE, 25'h0F0F0F0, 25'h1FFF000};
    vecs[2].c = {16'd23, 16'hFFE9, 16'd25, 16'd1};

    bus.in_valid  = 1'b0;  bus.in_a  = '0; bus.in_b  = '0; bus.in_last  = 1'b0;
    bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0;  bus8.in_a = '0; bus8.in_b = '0; bus8.in_last = 1'b0;
    bus8.out_ready = 1'b0;

    // Reset state, before any clock edge.
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_c",     bus.out_c,          64'd0);
    check("rst_out_sat",   64'(bus.out_sat),   64'd0);

    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single-chunk table: latency 1, term per lane, no saturation, then drain back to idle.
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].a, vecs[i].b, 1'b1);
      check({vecs[i].name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
      check({vecs[i].name, "_out_c"},     bus.out_c,          vecs[i].c);
      check({vecs[i].name, "_out_sat"},   64'(bus.out_sat),   64'd0);
      check({vecs[i].name, "_in_ready"},  64'(bus.in_ready),  64'd0);
      drain();
      check({vecs[i].name, "_idle_ready"}, 64'(bus.in_ready),  64'd1);
      check({vecs[i].name, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    end

    // Three-chunk job, every lane all-match: 75 each.
    send(AllOnes, AllOnes, 1'b0);
    check("three_c1_in_ready",  64'(bus.in_ready),  64'd1);
    check("three_c1_out_valid", 64'(bus.out_valid), 64'd0);
    send(AllOnes, AllOnes, 1'b0);
    check("three_c2_in_ready",  64'(bus.in_ready),  64'd1);
    check("three_c2_out_valid", 64'(bus.out_valid), 64'd0);
    send(AllOnes, AllOnes, 1'b1);
    check("three_out_valid", 64'(bus.out_valid), 64'd1);
    check("three_out_c",     bus.out_c, {4{16'd75}});

    // Backpressure: in_valid held high in Done must not be taken.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_a     = vecs[1].a;
      bus.in_b     = vecs[1].b;
      bus.in_last  = 1'b1;
      @(posedge clock);
      #1;
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_c",     bus.out_c, {4{16'd75}});
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clock);
    #1;
    check("bp_no_bubble_accept", 64'(bus.out_valid), 64'd0);

    // Saturation on the 8-bit instance: 6 chunks, lanes 25/-25/+1/+9 per chunk.
    a8 = {25'h00000FF, 25'h0000000, 25'h1FFFFFF, 25'h1FFFFFF};
    b8 = {25'h0000000, 25'h0000FFF, 25'h0000000, 25'h1FFFFFF};
    for (int i = 0; i < 6; i++) begin
      send8(a8, b8, (i == 5));
    end
    check("sat_out_valid", 64'(bus8.out_valid), 64'd1);
    check("sat_out_c",     64'(bus8.out_c), 64'({8'd54, 8'd6, 8'h80, 8'h7F}));
    check("sat_out_sat",   64'(bus8.out_sat), 64'b0011);
    drain8();
    send8(a8, b8, 1'b1);
    check("sat_next_out_c",   64'(bus8.out_c), 64'({8'd9, 8'd1, 8'hE7, 8'h19}));
    check("sat_next_out_sat", 64'(bus8.out_sat), 64'd0);
    drain8();

    // Reset mid-job: partial sum must be discarded.
    send(AllOnes, AllOnes, 1'b0);
    send(AllOnes, AllOnes, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_c",     bus.out_c,          64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_release_ready", 64'(bus.in_ready), 64'd1);
    send(vecs[0].a, vecs[0].b, 1'b1);
    check("midrst_fresh_valid", 64'(bus.out_valid), 64'd1);
    check("midrst_fresh_out_c", bus.out_c, vecs[0].c);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
